// File: rtl/pwm_pkg.sv
// pwm_pkg: state codes and widths shared by the PWM fade scheduler and its decoder successors.
package pwm_pkg;
    localparam int TICK_BASE_DEF = 6250000;
    localparam int DUTY_W = 8;
    localparam int CNT_W = 26;
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_R_UP   = 3'd1,
        S_R_DN   = 3'd2,
        S_G_UP   = 3'd3,
        S_G_DN   = 3'd4,
        S_B_UP   = 3'd5,
        S_B_DN   = 3'd6,
        S_MANUAL = 3'd7
    } state_t;
    // Channel slot within the packed {R,G,B} word: 2 = R, 1 = G, 0 = B.
    function automatic logic [1:0] chan_sel(input state_t s);
        return (s == S_R_UP || s == S_R_DN) ? 2'd2 : (s == S_G_UP || s == S_G_DN) ? 2'd1 : 2'd0;
    endfunction
endpackage

// File: rtl/pwm_fade_sched_if.sv
// pwm_fade_sched_if: control, manual override and duty outputs of the fade scheduler.
interface pwm_fade_sched_if;
    import pwm_pkg::*;
    logic              run;
    logic [1:0]        speed;
    logic              man_req;
    logic [3*DUTY_W-1:0] man_rgb;
    logic              man_ack;
    logic [DUTY_W-1:0] R_time_out;
    logic [DUTY_W-1:0] G_time_out;
    logic [DUTY_W-1:0] B_time_out;
    logic [2:0]        phase;
    modport master (output run, speed, man_req, man_rgb,
                    input  man_ack, R_time_out, G_time_out, B_time_out, phase);
    modport slave  (input  run, speed, man_req, man_rgb,
                    output man_ack, R_time_out, G_time_out, B_time_out, phase);
endinterface

// File: rtl/pwm_fade_sched_tick_prescaler.sv
// tick_prescaler: step tick every (TICK_BASE >> speed) running cycles; restarts on speed change.
module tick_prescaler
    import pwm_pkg::*;
#(
    parameter int TICK_BASE = TICK_BASE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);
    logic [CNT_W-1:0] cnt_q, cnt_d, period;
    logic [1:0] speed_q;
    logic chg;
    always_comb begin
        period = CNT_W'(TICK_BASE) >> speed_q;
        chg = speed != speed_q;
        tick = cnt_q == period - 1'b1 && run && !clr && !chg;
        cnt_d = (chg || clr || tick) ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        cnt_q <= !rst ? '0 : cnt_d;
        speed_q <= speed;
    end
endmodule

// File: rtl/pwm_fade_sched.sv
// pwm_fade_sched: R->G->B triangle fade sequencer with manual colour override.
module pwm_fade_sched
    import pwm_pkg::*;
#(
    parameter int TICK_BASE = TICK_BASE_DEF
) (
    input logic clk,
    input logic rst,
    pwm_fade_sched_if.slave bus
);
    state_t state_q, state_d;
    logic [3*DUTY_W-1:0] rgb_q, rgb_d;
    logic ack_q, ack_d, take, tick, up;
    logic [1:0] sel;
    logic [DUTY_W-1:0] cur;
    // Manual entry also suppresses the tick in the same cycle.
    assign take = bus.man_req && state_q != S_RESET && state_q != S_MANUAL;
    tick_prescaler #(.TICK_BASE(TICK_BASE)) u_pre (
        .clk   (clk),
        .rst   (rst),
        .run   (bus.run),
        .clr   (take || state_q == S_MANUAL),
        .speed (bus.speed),
        .tick  (tick)
    );
    always_comb begin
        state_d = state_q;
        rgb_d = rgb_q;
        ack_d = 1'b0;
        sel = chan_sel(state_q);
        cur = rgb_q[{sel, 3'b000} +: DUTY_W];
        up = state_q == S_R_UP || state_q == S_G_UP || state_q == S_B_UP;
        if (state_q == S_RESET) begin
            state_d = S_R_UP;
            rgb_d = '0;
        end else if (state_q == S_MANUAL) begin
            if (!bus.man_req) begin
                state_d = S_R_UP;
                rgb_d = '0;
            end
        end else if (take) begin
            state_d = S_MANUAL;
            rgb_d = bus.man_rgb;
            ack_d = 1'b1;
        end else if (tick) begin
            rgb_d[{sel, 3'b000} +: DUTY_W] = up ? cur + 1'b1 : cur - 1'b1;
            if (up && cur == 8'd254)
                state_d = state_t'(state_q + 3'd1);
            else if (!up && cur == 8'd1)
                state_d = state_q == S_B_DN ? S_R_UP : state_t'(state_q + 3'd1);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RESET;
            rgb_q <= '0;
            ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rgb_q <= rgb_d;
            ack_q <= ack_d;
        end
    end
    assign bus.man_ack = ack_q;
    assign bus.phase = state_q;
    assign bus.R_time_out = rgb_q[2*DUTY_W +: DUTY_W];
    assign bus.G_time_out = rgb_q[DUTY_W +: DUTY_W];
    assign bus.B_time_out = rgb_q[0 +: DUTY_W];
endmodule

// File: tb/tb_pwm_fade_sched.sv
// tb_pwm_fade_sched: directed checks of ramp, pause, manual override, collision, reset and speed.
module tb_pwm_fade_sched;
    import pwm_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errs = 0;
    int checks = 0;
    always #5 clk = ~clk;
    pwm_fade_sched_if a();
    pwm_fade_sched_if b();
    pwm_fade_sched #(.TICK_BASE(8))  dut_a (.clk(clk), .rst(rst), .bus(a));
    pwm_fade_sched #(.TICK_BASE(16)) dut_b (.clk(clk), .rst(rst), .bus(b));
    logic [23:0] rgb_a, rgb_b;
    assign rgb_a = {a.R_time_out, a.G_time_out, a.B_time_out};
    assign rgb_b = {b.R_time_out, b.G_time_out, b.B_time_out};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b0;
        step(3);
        rst = 1'b1;
    endtask
    initial begin
        int bad;
        a.run = 1'b1; a.speed = 2'd0; a.man_req = 1'b0; a.man_rgb = 24'h0;
        b.run = 1'b1; b.speed = 2'd2; b.man_req = 1'b0; b.man_rgb = 24'h0;
        rst = 1'b0;
        step(3);
        chk("rst_phase", a.phase, 0);
        chk("rst_rgb", rgb_a, 0);
        chk("rst_ack", a.man_ack, 0);
        rst = 1'b1;
        step(1);
        chk("rel_phase", a.phase, 1);
        step(6);
        chk("pre_tick", rgb_a, 24'h000000);
        step(1);
        chk("first_tick", rgb_a, 24'h010000);
        bad = 0;
        for (int i = 9; i <= 2039; i++) begin
            step(1);
            if (a.G_time_out != 0 || a.B_time_out != 0) bad++;
        end
        chk("gb_zero_red", bad, 0);
        chk("r254", rgb_a, 24'hFE0000);
        chk("r254_phase", a.phase, 1);
        step(1);
        chk("r255", rgb_a, 24'hFF0000);
        chk("r_dn_phase", a.phase, 2);
        step(2032);
        chk("r1_dn", rgb_a, 24'h010000);
        chk("r1_dn_phase", a.phase, 2);
        step(8);
        chk("r0_rgb", rgb_a, 24'h000000);
        chk("g_up_phase", a.phase, 3);
        step(8);
        chk("g_first", rgb_a, 24'h000100);
        // Mid-ramp reset
        do_reset();
        chk("mid_rst_phase", a.phase, 0);
        chk("mid_rst_rgb", rgb_a, 0);
        chk("mid_rst_ack", a.man_ack, 0);
        step(1);
        chk("mid_rel_phase", a.phase, 1);
        // Pause at R=100 with three counts already accumulated
        step(799);
        chk("r100", rgb_a, 24'h640000);
        step(3);
        a.run = 1'b0;
        step(50);
        chk("pause_hold", rgb_a, 24'h640000);
        a.run = 1'b1;
        step(4);
        chk("resume_early", rgb_a, 24'h640000);
        step(1);
        chk("resume_tick", rgb_a, 24'h650000);
        // Manual override at R=40
        do_reset();
        step(320);
        chk("r40", rgb_a, 24'h280000);
        a.man_req = 1'b1; a.man_rgb = 24'h123456;
        step(1);
        chk("man_rgb", rgb_a, 24'h123456);
        chk("man_phase", a.phase, 7);
        chk("man_ack_pulse", a.man_ack, 1);
        a.man_rgb = 24'hFFFFFF;
        step(1);
        chk("man_ack_once", a.man_ack, 0);
        chk("man_latched", rgb_a, 24'h123456);
        step(5);
        chk("man_ack_held", a.man_ack, 0);
        chk("man_stay", a.phase, 7);
        a.man_req = 1'b0;
        step(1);
        chk("man_exit_phase", a.phase, 1);
        chk("man_exit_rgb", rgb_a, 0);
        step(7);
        chk("exit_pre_tick", rgb_a, 0);
        step(1);
        chk("exit_tick", rgb_a, 24'h010000);
        // Manual request in the tick cycle at R=254
        do_reset();
        step(2039);
        chk("col_r254", rgb_a, 24'hFE0000);
        a.man_req = 1'b1; a.man_rgb = 24'hA5B6C7;
        step(1);
        chk("col_phase", a.phase, 7);
        chk("col_rgb", rgb_a, 24'hA5B6C7);
        // Reset overrides MANUAL
        rst = 1'b0;
        step(1);
        chk("man_rst_phase", a.phase, 0);
        chk("man_rst_rgb", rgb_a, 0);
        chk("man_rst_ack", a.man_ack, 0);
        a.man_req = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        chk("man_rst_rel", a.phase, 1);
        // Speed select on TICK_BASE=16
        do_reset();
        step(3);
        chk("spd_pre", rgb_b, 0);
        step(1);
        chk("spd_t1", rgb_b, 24'h010000);
        step(7);
        chk("spd_t2", rgb_b, 24'h020000);
        step(1);
        chk("spd_t3", rgb_b, 24'h030000);
        step(1);
        b.speed = 2'd0;
        step(16);
        chk("spd_chg_hold", rgb_b, 24'h030000);
        step(1);
        chk("spd_chg_tick", rgb_b, 24'h040000);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
